// File: rtl/baud_gen_multi.sv
// Programmable baud-rate generator: oversample, bit-rate and mid-bit ticks from one divider,
// with glitch-free divisor reload and start-bit realignment.
module baud_gen_multi #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 163,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sync_clear,
    input  logic                          div_load,
    input  logic [CNT_W-1:0]              div_in,
    output logic                          tick_os,
    output logic                          tick_bit,
    output logic                          tick_mid,
    output logic [$clog2(OVERSAMPLE)-1:0] os_index,
    output logic [CNT_W-1:0]              div_active
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic             pending;
    logic             run;
    logic             wrap;

    assign run  = enable && !sync_clear;
    assign wrap = run && (cnt >= div_active);

    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // OVERSAMPLE is a power of two, so the natural roll-over gives the modulo.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            os_index <= '0;
        end else if (wrap) begin
            os_index <= os_index + 1'b1;
        end
    end

    // A new divisor only takes effect at a period boundary unless the generator is idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_active <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pending    <= 1'b0;
        end else if (div_load && !enable) begin
            div_active <= div_in;
            pending    <= 1'b0;
        end else if (wrap) begin
            if (div_load) begin
                div_active <= div_in;
            end else if (pending) begin
                div_active <= pend_div;
            end
            pending <= 1'b0;
        end else if (div_load) begin
            pend_div <= div_in;
            pending  <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            tick_mid <= 1'b0;
        end else begin
            tick_os  <= wrap;
            tick_bit <= wrap && (os_index == OS_LAST);
            tick_mid <= wrap && (os_index == OS_MID_PRE);
        end
    end

endmodule
